// File: rtl/rr_grant_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant_ctrl
// Description : Round-robin bus arbiter control stage. Masks requests by the
//               last owner, registers a one-hot grant plus binary index, and
//               holds it until the owner releases or the hold limit expires.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_ctrl #(
  parameter int N_REQ    = 4,
  parameter int W_IDX    = 2,
  parameter int MAX_HOLD = 16,
  parameter int W_HOLD   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  input  logic             lock,
  output logic [N_REQ-1:0] gnt,
  output logic [W_IDX-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  localparam logic [W_HOLD-1:0] c_hold_last = W_HOLD'(MAX_HOLD - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] w_gnt_nxt;
  logic [W_IDX-1:0] r_gnt_idx;
  logic [W_IDX-1:0] w_gnt_idx_nxt;
  logic [W_IDX-1:0] r_last_idx;
  logic [W_IDX-1:0] w_last_idx_nxt;
  logic [W_HOLD-1:0] r_hold_cnt;
  logic [W_HOLD-1:0] w_hold_cnt_nxt;
  logic             r_gnt_valid;
  logic             r_timeout;
  logic             w_timeout_nxt;

  logic [N_REQ-1:0] w_masked;
  logic [N_REQ-1:0] w_pick;
  logic [W_IDX-1:0] w_win;
  logic             w_rel_done;
  logic             w_rel_wd;
  logic             w_rel_hold;

  // Round-robin winner: requests above the last owner first, else wrap to bit 0.
  always_comb begin
    w_masked = '0;
    w_win    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_masked[i] = req[i] && (W_IDX'(i) > r_last_idx);
    end
    w_pick = (|w_masked) ? w_masked : req;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_pick[i]) w_win = W_IDX'(i);
    end
  end

  // Release causes: normal finish, owner withdrew, hold limit reached.
  always_comb begin
    w_rel_done = done && !lock;
    w_rel_wd   = !req[r_gnt_idx];
    w_rel_hold = (r_hold_cnt == c_hold_last);
  end

  // Next-state and next-output logic for the grant FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_gnt_idx_nxt  = r_gnt_idx;
    w_last_idx_nxt = r_last_idx;
    w_hold_cnt_nxt = r_hold_cnt;
    w_timeout_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_nxt       = ST_OWN;
          w_gnt_nxt         = '0;
          w_gnt_nxt[w_win]  = 1'b1;
          w_gnt_idx_nxt     = w_win;
          w_last_idx_nxt    = w_win;
          w_hold_cnt_nxt    = '0;
        end
      end
      ST_OWN: begin
        if (w_rel_done || w_rel_wd || w_rel_hold) begin
          // Returning to IDLE gives the one-cycle bus turnaround gap.
          w_state_nxt    = ST_IDLE;
          w_gnt_nxt      = '0;
          w_gnt_idx_nxt  = '0;
          w_hold_cnt_nxt = '0;
          w_timeout_nxt  = w_rel_hold && !w_rel_done && !w_rel_wd;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + W_HOLD'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // State and registered outputs; last_idx resets to the top so bit 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_last_idx  <= W_IDX'(N_REQ - 1);
      r_hold_cnt  <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_idx   <= w_gnt_idx_nxt;
      r_last_idx  <= w_last_idx_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_gnt_valid <= |w_gnt_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_grant_ctrl
// Description : Directed self-checking bench for rr_grant_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_grant_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic       lock;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_checks;
  int n_fail;

  rr_grant_ctrl #(
    .N_REQ(4), .W_IDX(2), .MAX_HOLD(16), .W_HOLD(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .lock(lock),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Structural invariants on every sampled cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if ($countones(gnt) > 1 || gnt_valid !== (|gnt) ||
          (gnt != 4'b0 && gnt[gnt_idx] !== 1'b1) || (gnt == 4'b0 && gnt_idx !== 2'd0)) begin
        n_fail++;
        $display("FAIL invariant: gnt=%b gnt_idx=%0d gnt_valid=%b", gnt, gnt_idx, gnt_valid);
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0; req = 4'b0; done = 1'b0; lock = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; done = 1'b0; lock = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0 || gnt_idx !== 2'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: gnt=%b idx=%0d valid=%b to=%b, want all zero", gnt, gnt_idx, gnt_valid, timeout);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g [13] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                               4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
    logic       pulse [13] = '{0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
    apply_reset();
    req = 4'b1111;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      n_checks++;
      if (gnt !== exp_g[k]) begin
        n_fail++;
        $display("FAIL rotation[%0d]: gnt=%b want %b", k, gnt, exp_g[k]);
      end
      done = pulse[k];
    end
    done = 1'b0;
  endtask

  task automatic test_single_req();
    apply_reset();
    req = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0100 || gnt_idx !== 2'd2) begin
      n_fail++;
      $display("FAIL single_grant: gnt=%b idx=%0d want 0100 idx 2", gnt, gnt_idx);
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    n_checks++;
    if (gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_release: gnt=%b want 0000", gnt);
    end
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0100 || gnt_idx !== 2'd2) begin
      n_fail++;
      $display("FAIL single_regrant: gnt=%b idx=%0d want 0100 idx 2", gnt, gnt_idx);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    req = 4'b0010; lock = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 4) done = 1'b1;   // locked done must not release
      else        done = 1'b0;
      n_checks++;
      if (gnt !== 4'b0010 || timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_hold[%0d]: gnt=%b to=%b want 0010 to 0", k, gnt, timeout);
      end
    end
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_fire: gnt=%b to=%b want 0000 to 1", gnt, timeout);
    end
    req = 4'b0000; lock = 1'b0;
    @(negedge clk);
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pulse_width: to=%b want 0", timeout);
    end
  endtask

  task automatic test_withdraw();
    apply_reset();
    req = 4'b0001; lock = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (gnt !== 4'b0001) begin
        n_fail++;
        $display("FAIL withdraw_hold[%0d]: gnt=%b want 0001", k, gnt);
      end
      if (k == 2) req = 4'b0111;   // other requesters arrive mid-grant
      if (k == 5) req = 4'b0110;   // owner withdraws
    end
    @(negedge clk);
    lock = 1'b0;
    n_checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL withdraw_release: gnt=%b to=%b want 0000 to 0", gnt, timeout);
    end
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0010 || gnt_idx !== 2'd1) begin
      n_fail++;
      $display("FAIL withdraw_next: gnt=%b idx=%0d want 0010 idx 1", gnt, gnt_idx);
    end
    req = 4'b0000;
  endtask

  task automatic test_done_at_limit();
    apply_reset();
    req = 4'b0100;
    repeat (16) @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL limit_hold: gnt=%b want 0100", gnt);
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    n_checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL limit_done: gnt=%b to=%b want 0000 to 0", gnt, timeout);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req = 4'b1000;
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL areset_setup: gnt=%b want 1000", gnt);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_clear: gnt=%b valid=%b to=%b want 0000 0 0", gnt, gnt_valid, timeout);
    end
    @(negedge clk);
    rst_n = 1'b1; req = 4'b1010;
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0010 || gnt_idx !== 2'd1) begin
      n_fail++;
      $display("FAIL areset_priority: gnt=%b idx=%0d want 0010 idx 1", gnt, gnt_idx);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_rotation();
    test_single_req();
    test_timeout();
    test_withdraw();
    test_done_at_limit();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
